ram_arbiter: RTL

Shares the external SRAM between the CPU bus and the supervisor's debug memory port. On a supervisor request it raises HOLD, waits for HLDA, then owns the address, data and RAM strobes for one timed SRAM access. It returns the bus with a completion acknowledge. It sits at the top level between the CPU-side memory control strobes and the RAM pins.

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/ram_arbiter_timer.sv | 27 ++
 rtl/ram_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the supervisor/CPU SRAM arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD_WAIT = 3'd1,
        ST_SETUP     = 3'd2,
        ST_ACCESS    = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_DRAIN     = 3'd5
    } ram_arb_state_t;

    localparam int DEFAULT_ADDR_W = 23;
    localparam int BE_HIGH        = 1;
    localparam int BE_LOW         = 0;

    // One counter serves both the access wait and the HLDA timeout, so it must hold the larger span.
    function automatic int cnt_width(input int wait_states, input int hlda_timeout);
        int span;
        span = (wait_states + 1 > hlda_timeout + 1) ? wait_states + 1 : hlda_timeout + 1;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_timer.sv
// arb_timer: loadable saturating down-counter; done while the count sits at zero.
module arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         _rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: lends the external SRAM to the supervisor debug port via HOLD/HLDA for one timed access.
// Define RAM_ARB_TIMEOUT_EN to abort with sv_err when HLDA never arrives.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WAIT_STATES  = 2,
    parameter int HLDA_TIMEOUT = 255,
    parameter int ADDR_W       = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic              sv_req,
    input  logic              sv_wr,
    input  logic [ADDR_W-1:0] sv_addr,
    input  logic [1:0]        sv_be,
    input  logic [15:0]       sv_wdata,
    output logic [15:0]       sv_rdata,
    output logic              sv_ack,
    output logic              sv_err,
    output logic              hold,
    input  logic              hlda,
    input  logic              cpu_ramcs,
    input  logic              cpu_ramwe,
    output logic              ramcs,
    output logic              ramwe,
    output logic              owner,
    output logic [ADDR_W-1:0] bus_a,
    output logic              _bus_bhe,
    output logic              _bus_ble,
    input  logic [15:0]       d_in,
    output logic [15:0]       d_out,
    output logic [1:0]        d_oe
);

    localparam int CNT_W = cnt_width(WAIT_STATES, HLDA_TIMEOUT);
    localparam logic [CNT_W-1:0] ACCESS_LOAD  = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'((HLDA_TIMEOUT > 0) ? HLDA_TIMEOUT - 1 : 0);

    ram_arb_state_t    state_reg, state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic              wr_reg;
    logic [1:0]        be_reg;
    logic [15:0]       wdata_reg;

    logic              hold_reg, hold_next;
    logic              owner_reg, owner_next;
    logic              ramcs_reg, ramcs_next;
    logic              ramwe_reg, ramwe_next;
    logic              ack_reg, ack_next;
    logic [ADDR_W-1:0] bus_a_reg, bus_a_next;
    logic [1:0]        be_n_reg, be_n_next;
    logic [1:0]        d_oe_reg, d_oe_next;

    logic              latch_req;
    logic              capture;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_done;
    logic [CNT_W-1:0]  tmr_load_val;
    logic              pass_through;

`ifdef RAM_ARB_TIMEOUT_EN
    logic              err_reg, err_next;
`endif

    arb_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        ._rst     (_rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_reg <= ST_IDLE;
            hold_reg  <= 1'b0;
            owner_reg <= 1'b0;
            ramcs_reg <= 1'b1;
            ramwe_reg <= 1'b1;
            ack_reg   <= 1'b0;
            bus_a_reg <= '0;
            be_n_reg  <= 2'b11;
            d_oe_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            owner_reg <= owner_next;
            ramcs_reg <= ramcs_next;
            ramwe_reg <= ramwe_next;
            ack_reg   <= ack_next;
            bus_a_reg <= bus_a_next;
            be_n_reg  <= be_n_next;
            d_oe_reg  <= d_oe_next;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            addr_reg  <= '0;
            wr_reg    <= 1'b0;
            be_reg    <= 2'b00;
            wdata_reg <= '0;
        end else if (latch_req) begin
            addr_reg  <= sv_addr;
            wr_reg    <= sv_wr;
            be_reg    <= sv_be;
            wdata_reg <= sv_wdata;
        end
    end

    always_comb begin
        state_next   = state_reg;
        latch_req    = 1'b0;
        capture      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
        err_next     = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (sv_req) begin
                    latch_req    = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = TIMEOUT_LOAD;
                    state_next   = ST_HOLD_WAIT;
                end
            end
            ST_HOLD_WAIT: begin
                // hlda is tested first so a grant on the expiry cycle still proceeds.
                if (hlda) begin
                    state_next = ST_SETUP;
                end
`ifdef RAM_ARB_TIMEOUT_EN
                else if (tmr_done) begin
                    err_next   = 1'b1;
                    state_next = ST_DRAIN;
                end else begin
                    tmr_dec = 1'b1;
                end
`endif
            end
            ST_SETUP: begin
                if (be_reg == 2'b00) begin
                    state_next = ST_RELEASE;
                end else begin
                    tmr_load     = 1'b1;
                    tmr_load_val = ACCESS_LOAD;
                    state_next   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (tmr_done) begin
                    capture    = !wr_reg;
                    state_next = ST_RELEASE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RELEASE: state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!hlda) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered in the state they belong to.
        owner_next = (state_next == ST_SETUP) || (state_next == ST_ACCESS) || (state_next == ST_RELEASE);
        hold_next  = owner_next || (state_next == ST_HOLD_WAIT);
        ramcs_next = (state_next != ST_ACCESS);
        ramwe_next = !((state_next == ST_ACCESS) && wr_reg);
        d_oe_next  = (wr_reg && ((state_next == ST_ACCESS) || (state_next == ST_RELEASE))) ? be_reg : 2'b00;
        ack_next   = (state_next == ST_RELEASE);
        bus_a_next = owner_next ? addr_reg : '0;
        be_n_next  = owner_next ? ~be_reg : 2'b11;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] rdata_lane_reg;

        always_ff @(posedge clk or negedge _rst) begin
            if (!_rst) begin
                rdata_lane_reg <= 8'h00;
            end else if (capture && be_reg[gi]) begin
                rdata_lane_reg <= d_in[gi*8 +: 8];
            end
        end

        assign sv_rdata[gi*8 +: 8] = rdata_lane_reg;
    end

`ifdef RAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
    assign sv_err = err_reg;
`else
    assign sv_err = 1'b0;
`endif

    // The CPU keeps direct control of the RAM strobes whenever the arbiter does not own the bus.
    assign pass_through = (state_reg == ST_IDLE) || (state_reg == ST_HOLD_WAIT) || (state_reg == ST_DRAIN);
    assign ramcs        = !_rst || (pass_through ? cpu_ramcs : ramcs_reg);
    assign ramwe        = !_rst || (pass_through ? cpu_ramwe : ramwe_reg);

    assign sv_ack   = ack_reg;
    assign hold     = hold_reg;
    assign owner    = owner_reg;
    assign bus_a    = bus_a_reg;
    assign _bus_bhe = be_n_reg[BE_HIGH];
    assign _bus_ble = be_n_reg[BE_LOW];
    assign d_out    = wdata_reg;
    assign d_oe     = d_oe_reg;

endmodule
